mvm_stream_driver: RTL and testbench
====================================

MVM_STREAM_DRIVER -- requirements
Module: mvm_stream_driver

Interface
REQ-001 Parameter K, default 4: matrix dimension.
REQ-002 Parameter NOP, default K*K+2*K (24): operand bytes per transaction.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load_en  in  1  write operand buffer this cycle.
REQ-006 load_addr  in  5  operand buffer index, 0..NOP-1.
REQ-007 load_data  in  8  signed operand byte.
REQ-008 start  in  1  begin one transaction.
REQ-009 m_valid  out  1  outbound operand byte valid.
REQ-010 m_ready  in  1  downstream accepts the outbound byte.
REQ-011 m_data  out  8  signed outbound operand byte.
REQ-012 s_valid  in  1  inbound result valid.
REQ-013 s_ready  out  1  block accepts the inbound result.
REQ-014 s_data  in  16  signed inbound result.
REQ-015 res_addr  in  2  result buffer read index.
REQ-016 res_data  out  16  result buffer word at res_addr, combinational read.
REQ-017 busy  out  1  high in SEND or RECV.
REQ-018 done  out  1  high in DONE.

Function
REQ-019 Operand buffer layout: index 0..K*K-1 = matrix M row-major; K*K..K*K+K-1 = bias b; K*K+K..NOP-1 = vector x.
REQ-020 States: IDLE, SEND, RECV, DONE; IDLE after reset.
REQ-021 IDLE or DONE with start=1 -> SEND next cycle; send counter cleared, result counter cleared.
REQ-022 In SEND: m_valid=1, m_data=buffer[send counter]; counter increments on m_valid&&m_ready.
REQ-023 m_data held stable while m_valid&&!m_ready; m_valid never drops before acceptance.
REQ-024 Acceptance of byte NOP-1 -> RECV next cycle, m_valid=0 that cycle.
REQ-025 In RECV: s_ready=1; s_valid&&s_ready stores s_data into result[result counter], counter increments.
REQ-026 Acceptance of result K-1 -> DONE next cycle, s_ready=0 that cycle.
REQ-027 s_ready=0 outside RECV; s_valid outside RECV ignored, nothing stored.
REQ-028 start while busy ignored.
REQ-029 load_en while busy ignored; load_en with load_addr >= NOP ignored.
REQ-030 load_en and start in the same cycle from IDLE/DONE: write committed, SEND begins next cycle, written value is transmitted.
REQ-031 Result buffer retains values until overwritten by the next transaction; readable in any state.
REQ-032 No arithmetic on data; bytes forwarded and results stored bit-exact.

Reset
REQ-033 reset forces IDLE, m_valid=0, s_ready=0, busy=0, done=0, counters 0, result buffer 0.
REQ-034 reset mid-SEND or mid-RECV aborts the transaction; operand buffer contents are not cleared.
REQ-035 reset has priority over start, load_en and both handshakes.

Structure
REQ-036 Shared package holds K, NOP, state enum, and operand region base indices (M_BASE=0, B_BASE=16, X_BASE=20).
REQ-037 Operand buffer is an instance of the existing memory sub-module (8-bit, NOP entries); result buffer is a local register array.
REQ-038 Counters sized to index NOP and K inclusive without overflow.

Verification
REQ-039 Load M=identity, b=1..4, x=10,20,30,40; start; m_ready=1 -> 24 bytes in order in 24 consecutive cycles; inject 11,22,33,44 -> res_data reads 11,22,33,44, done=1.
REQ-040 m_ready toggling 1,0,0,1 pattern -> no byte duplicated or dropped, m_data stable during stalls, all 24 sent.
REQ-041 s_valid pulsed during SEND with s_data=0x7FFF -> ignored; later results stored from index 0.
REQ-042 start asserted at byte 5 of SEND, load_en at byte 7 -> no restart, buffer unchanged, sequence completes.
REQ-043 reset at byte 12 of SEND -> IDLE, m_valid=0; new start resends full 24 bytes from index 0.
REQ-044 Negative result -300 (0xFED4) received -> res_data=0xFED4; back-to-back second transaction from DONE overwrites results.

Source files
------------

// File: rtl/mvm_stream_driver_pkg.sv
// Shared constants, operand-buffer layout and FSM state type for the MVM stream driver.
package mvm_stream_driver_pkg;

    localparam int unsigned K      = 4;
    localparam int unsigned NOP    = K * K + 2 * K;
    localparam int unsigned M_BASE = 0;
    localparam int unsigned B_BASE = K * K;
    localparam int unsigned X_BASE = K * K + K;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRecv,
        StDone
    } state_e;

    // Bits needed to hold 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mvm_stream_driver_mem.sv
// Simple register-file memory: one synchronous write port, one combinational read port.
module mvm_stream_driver_mem #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 24,
    parameter int unsigned AddrW = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem_q [Depth];

    // Contents survive reset on purpose; only explicit writes change them.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < Depth)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = (32'(rd_addr) < Depth) ? mem_q[rd_addr] : '0;

endmodule

// File: rtl/mvm_stream_driver.sv
// Streams the operand buffer out over a valid/ready port, then collects K results
// from the inbound port into a readable result buffer.
module mvm_stream_driver
    import mvm_stream_driver_pkg::*;
#(
    parameter int unsigned K   = mvm_stream_driver_pkg::K,
    parameter int unsigned NOP = K * K + 2 * K
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [4:0]  load_addr,
    input  logic [7:0]  load_data,
    input  logic        start,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic [1:0]  res_addr,
    output logic [15:0] res_data,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AddrW   = 5;
    localparam int unsigned SendW   = cnt_width(NOP);
    localparam int unsigned ResCntW = cnt_width(K);
    localparam int unsigned ResIdxW = (K > 1) ? $clog2(K) : 1;

    state_e               state_q, state_d;
    logic [SendW-1:0]     send_cnt_q, send_cnt_d;
    logic [ResCntW-1:0]   res_cnt_q, res_cnt_d;
    logic [15:0]          result_q [K];
    logic                 res_we;
    logic                 op_we;
    logic [ResIdxW-1:0]   res_idx;

    assign busy    = (state_q == StSend) || (state_q == StRecv);
    assign done    = (state_q == StDone);
    assign m_valid = (state_q == StSend);
    assign s_ready = (state_q == StRecv);

    // Loads are only accepted while no transaction is in flight, and reset wins.
    assign op_we   = load_en && !busy && !reset && (32'(load_addr) < NOP);
    assign res_idx = res_cnt_q[ResIdxW-1:0];

    mvm_stream_driver_mem #(
        .Width (8),
        .Depth (NOP),
        .AddrW (AddrW)
    ) u_op_mem (
        .clk     (clk),
        .wr_en   (op_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_addr (AddrW'(send_cnt_q)),
        .rd_data (m_data)
    );

    always_comb begin
        state_d    = state_q;
        send_cnt_d = send_cnt_q;
        res_cnt_d  = res_cnt_q;
        res_we     = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d    = StSend;
                    send_cnt_d = '0;
                    res_cnt_d  = '0;
                end
            end
            StSend: begin
                if (m_ready) begin
                    send_cnt_d = send_cnt_q + SendW'(1);
                    if (send_cnt_q == SendW'(NOP - 1)) begin
                        state_d = StRecv;
                    end
                end
            end
            StRecv: begin
                if (s_valid) begin
                    res_we    = 1'b1;
                    res_cnt_d = res_cnt_q + ResCntW'(1);
                    if (res_cnt_q == ResCntW'(K - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            send_cnt_q <= '0;
            res_cnt_q  <= '0;
            for (int i = 0; i < int'(K); i++) begin
                result_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            send_cnt_q <= send_cnt_d;
            res_cnt_q  <= res_cnt_d;
            if (res_we) begin
                result_q[res_idx] <= s_data;
            end
        end
    end

    assign res_data = (32'(res_addr) < K) ? result_q[res_addr] : '0;

endmodule

// File: tb/tb_mvm_stream_driver.sv
// Directed bench for mvm_stream_driver: operand bytes and results are predicted into queues.
module tb_mvm_stream_driver;

    localparam int K   = 4;
    localparam int NOP = 24;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [1:0]  res_addr;
    logic [15:0] res_data;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  op_model [NOP];
    logic [7:0]  byte_q [$];
    logic [15:0] res_q [$];
    int          sent;

    always #5 clk = ~clk;

    mvm_stream_driver dut (
        .clk       (clk),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .res_addr  (res_addr),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int addr, input logic [7:0] data);
        load_en   = 1'b1;
        load_addr = 5'(addr);
        load_data = data;
        if (addr < NOP) op_model[addr] = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Optionally writes one operand in the same cycle as start.
    task automatic kick(input bit with_load, input int addr, input logic [7:0] data);
        if (with_load) begin
            load_en   = 1'b1;
            load_addr = 5'(addr);
            load_data = data;
            op_model[addr] = data;
        end
        start = 1'b1;
        byte_q.delete();
        for (int i = 0; i < NOP; i++) byte_q.push_back(op_model[i]);
        @(negedge clk);
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic send_phase(input bit stall, input bit intrude, input int reset_at,
                              output int n_sent);
        logic [7:0] held = '0;
        logic [7:0] exp;
        bit         was_stalled = 1'b0;
        int         cyc = 0;
        n_sent = 0;
        while (n_sent < NOP && cyc < 400) begin
            m_ready   = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            s_valid   = intrude && (n_sent == 3);
            s_data    = 16'h7FFF;
            start     = intrude && (n_sent == 5);
            load_en   = intrude && (n_sent == 7);
            load_addr = 5'd0;
            load_data = 8'h5A;
            if (reset_at >= 0 && n_sent == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                break;
            end
            #1;
            check("m_valid_in_send", m_valid, 1'b1);
            check("busy_in_send", busy, 1'b1);
            if (was_stalled) check("m_data_stall_hold", m_data, held);
            if (m_ready) begin
                if (byte_q.size() == 0) begin
                    check("byte_queue_underflow", 1'b1, 1'b0);
                    exp = 'x;
                end else begin
                    exp = byte_q.pop_front();
                end
                check($sformatf("m_data_byte%0d", n_sent), m_data, exp);
                n_sent++;
                was_stalled = 1'b0;
            end else begin
                held        = m_data;
                was_stalled = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 400) check("send_timeout", 1'b1, 1'b0);
        s_valid = 1'b0;
        start   = 1'b0;
        load_en = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic recv_phase(input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3);
        logic [15:0] vals [4];
        vals = '{v0, v1, v2, v3};
        #1;
        check("m_valid_after_send", m_valid, 1'b0);
        for (int i = 0; i < K; i++) begin
            s_valid = 1'b1;
            s_data  = vals[i];
            #1;
            check("s_ready_in_recv", s_ready, 1'b1);
            res_q.push_back(vals[i]);
            @(negedge clk);
        end
        s_valid = 1'b0;
        #1;
        check("done_after_recv", done, 1'b1);
        check("s_ready_in_done", s_ready, 1'b0);
        check("busy_in_done", busy, 1'b0);
        for (int i = 0; i < K; i++) begin
            res_addr = 2'(i);
            #1;
            check($sformatf("res_data%0d", i), res_data, res_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
        m_ready = 1'b0; s_valid = 1'b0; s_data = '0; res_addr = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_m_valid", m_valid, 1'b0);
        check("reset_s_ready", s_ready, 1'b0);
        for (int i = 0; i < K; i++) begin
            res_addr = 2'(i);
            #1;
            check("reset_res_data", res_data, 16'h0000);
        end

        // Identity matrix, bias 1..4, x = 10..40; last x written alongside start.
        for (int i = 0; i < K * K; i++) load(i, ((i % (K + 1)) == 0) ? 8'd1 : 8'd0);
        for (int i = 0; i < K; i++) load(16 + i, 8'(i + 1));
        for (int i = 0; i < K - 1; i++) load(20 + i, 8'(10 * (i + 1)));
        load(31, 8'hEE);
        kick(1'b1, 23, 8'd40);
        send_phase(1'b0, 1'b0, -1, sent);
        check("sent_plain", sent, NOP);
        recv_phase(16'd11, 16'd22, 16'd33, 16'd44);

        // Back-to-back from DONE, stalling downstream, with a negative result.
        load(5, 8'h80);
        kick(1'b0, 0, 8'h00);
        send_phase(1'b1, 1'b0, -1, sent);
        check("sent_stall", sent, NOP);
        recv_phase(16'hFED4, 16'h0005, 16'hFFFF, 16'h7FFF);

        // Stray s_valid, start and load_en during SEND must all be ignored.
        kick(1'b0, 0, 8'h00);
        send_phase(1'b0, 1'b1, -1, sent);
        check("sent_intrude", sent, NOP);
        recv_phase(16'h1234, 16'h8000, 16'h0001, 16'hABCD);

        // Reset mid-SEND, then a clean full transaction.
        kick(1'b0, 0, 8'h00);
        send_phase(1'b0, 1'b0, 12, sent);
        check("sent_before_reset", sent, 12);
        #1;
        check("abort_m_valid", m_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        res_addr = 2'd1;
        #1;
        check("abort_res_cleared", res_data, 16'h0000);
        @(negedge clk);
        kick(1'b0, 0, 8'h00);
        send_phase(1'b0, 1'b0, -1, sent);
        check("sent_after_reset", sent, NOP);
        recv_phase(16'h0101, 16'h0202, 16'h0303, 16'h0404);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
